// File: rtl/dac_spi_frame_rx.sv
// SPI slave for the DRS-board DAC write stream on the loopback/monitor path.
// Synchronizes CS/SCK/SDI, shifts 24-bit MSB-first frames, decodes
// cmd/addr/data, keeps shadow copies of the five DAC channels, and reports
// frame errors plus a "channel set complete" status.
module dac_spi_frame_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DAC_CS,
  input  logic        DAC_SCK,
  input  logic        DAC_SDI,
  input  logic        clear_status,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [3:0]  frame_cmd,
  output logic [3:0]  frame_addr,
  output logic [15:0] frame_data,
  output logic [15:0] DAC_ROFS,
  output logic [15:0] DAC_OOFS,
  output logic [15:0] DAC_BIAS,
  output logic [15:0] DAC_CALP,
  output logic [15:0] DAC_CALN,
  output logic [7:0]  ctrl_cnt,
  output logic        all_set
);

  localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
  localparam logic [3:0] CMD_CTRL         = 4'b0100;

  localparam logic [3:0] ADDR_ROFS = 4'd3;
  localparam logic [3:0] ADDR_OOFS = 4'd7;
  localparam logic [3:0] ADDR_BIAS = 4'd6;
  localparam logic [3:0] ADDR_CALP = 4'd2;
  localparam logic [3:0] ADDR_CALN = 4'd1;

  // Written-mask bit positions, one per shadow channel.
  localparam int CH_ROFS = 0;
  localparam int CH_OOFS = 1;
  localparam int CH_BIAS = 2;
  localparam int CH_CALP = 3;
  localparam int CH_CALN = 4;

  localparam logic [4:0] CNT_SAT = 5'd31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    EVAL  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic                   cs_q;
  logic                   sck_q;
  logic                   cs_s;
  logic                   sck_s;
  logic                   sdi_s;
  logic                   cs_fall;
  logic                   cs_rise;
  logic                   sck_rise;

  // Equal-depth synchronizer chains so SDI stays aligned with SCK.
  // NOTE: CS stages (and the CS history bit) reset to 1, the idle level, so
  // leaving reset with CS already high never looks like a rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_sync  <= '1;
      sck_sync <= '0;
      sdi_sync <= '0;
      cs_q     <= 1'b1;
      sck_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, which is what turns this into a shift chain.
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], DAC_CS};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], DAC_SCK};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], DAC_SDI};
      cs_q     <= cs_s;
      sck_q    <= sck_s;
    end
  end

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync[SYNC_STAGES-1];
  assign cs_fall  = cs_q & ~cs_s;
  assign cs_rise  = ~cs_q & cs_s;
  assign sck_rise = ~sck_q & sck_s;

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  state_t state;
  state_t state_next;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic: IDLE waits for CS fall, SHIFT runs until CS rise,
  // EVAL lasts exactly one cycle.
  always_comb begin
    // NOTE: a default on every path keeps this block purely combinational;
    // a missing branch assignment would infer a latch.
    state_next = state;
    unique case (state)
      IDLE:    if (cs_fall) state_next = SHIFT;
      SHIFT:   if (cs_rise) state_next = EVAL;
      EVAL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Shift register and bit counter
  // ---------------------------------------------------------------------
  logic [23:0] shift;
  logic [4:0]  bit_cnt;

  // Capture SDI on each SCK rise while framed; an SCK rise in the same cycle
  // as CS rise belongs to no frame and is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift   <= '0;
      bit_cnt <= '0;
    end else begin
      if (state == IDLE && cs_fall) begin
        shift   <= '0;
        bit_cnt <= '0;
      end else if (state == SHIFT && !cs_rise && sck_rise) begin
        shift <= {shift[22:0], sdi_s};
        if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 5'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Frame decode
  // ---------------------------------------------------------------------
  logic       eval_ok;
  logic       eval_bad;
  logic [3:0] rx_cmd;
  logic [3:0] rx_addr;
  logic [4:0] wr_sel;
  logic       ctrl_inc;
  logic [4:0] mask;
  logic [4:0] mask_next;
  logic [7:0] ctrl_next;

  assign eval_ok  = (state == EVAL) && (bit_cnt == 5'(FRAME_BITS));
  assign eval_bad = (state == EVAL) && (bit_cnt != 5'(FRAME_BITS));
  assign rx_cmd   = shift[23:20];
  assign rx_addr  = shift[19:16];
  assign ctrl_inc = eval_ok && (rx_cmd == CMD_CTRL);

  // One-hot shadow write select for a good write-and-update frame.
  always_comb begin
    wr_sel = '0;
    if (eval_ok && rx_cmd == CMD_WRITE_UPDATE) begin
      unique case (rx_addr)
        ADDR_ROFS: wr_sel[CH_ROFS] = 1'b1;
        ADDR_OOFS: wr_sel[CH_OOFS] = 1'b1;
        ADDR_BIAS: wr_sel[CH_BIAS] = 1'b1;
        ADDR_CALP: wr_sel[CH_CALP] = 1'b1;
        ADDR_CALN: wr_sel[CH_CALN] = 1'b1;
        default:   wr_sel = '0;
      endcase
    end
  end

  // Status update: clear_status acts first, then this cycle's frame.
  always_comb begin
    mask_next = (clear_status ? 5'd0 : mask) | wr_sel;
    ctrl_next = (clear_status ? 8'd0 : ctrl_cnt) + {7'd0, ctrl_inc};
  end

  // Result pulses, decoded fields and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_cmd   <= '0;
      frame_addr  <= '0;
      frame_data  <= '0;
      mask        <= '0;
      all_set     <= 1'b0;
      ctrl_cnt    <= '0;
    end else begin
      frame_valid <= eval_ok;
      frame_err   <= eval_bad;
      if (eval_ok) begin
        frame_cmd  <= rx_cmd;
        frame_addr <= rx_addr;
        frame_data <= shift[15:0];
      end
      mask     <= mask_next;
      all_set  <= &mask_next;
      ctrl_cnt <= ctrl_next;
    end
  end

  // Shadow copies of the five DAC channels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      DAC_ROFS <= '0;
      DAC_OOFS <= '0;
      DAC_BIAS <= '0;
      DAC_CALP <= '0;
      DAC_CALN <= '0;
    end else begin
      if (wr_sel[CH_ROFS]) DAC_ROFS <= shift[15:0];
      if (wr_sel[CH_OOFS]) DAC_OOFS <= shift[15:0];
      if (wr_sel[CH_BIAS]) DAC_BIAS <= shift[15:0];
      if (wr_sel[CH_CALP]) DAC_CALP <= shift[15:0];
      if (wr_sel[CH_CALN]) DAC_CALN <= shift[15:0];
    end
  end

endmodule

// File: tb/tb_dac_spi_frame_rx.sv
// Self-checking bench for dac_spi_frame_rx: frames are driven pin-level, a
// behavioural model predicts each result, and a monitor compares every
// frame_valid/frame_err pulse against the queued prediction.
module tb_dac_spi_frame_rx;

  localparam int SYNC_STAGES = 2;
  localparam int FRAME_BITS  = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic        DAC_CS;
  logic        DAC_SCK;
  logic        DAC_SDI;
  logic        clear_status;
  logic        frame_valid;
  logic        frame_err;
  logic [3:0]  frame_cmd;
  logic [3:0]  frame_addr;
  logic [15:0] frame_data;
  logic [15:0] DAC_ROFS, DAC_OOFS, DAC_BIAS, DAC_CALP, DAC_CALN;
  logic [7:0]  ctrl_cnt;
  logic        all_set;

  dac_spi_frame_rx #(.SYNC_STAGES(SYNC_STAGES), .FRAME_BITS(FRAME_BITS)) dut (
    .clk(clk), .rst(rst),
    .DAC_CS(DAC_CS), .DAC_SCK(DAC_SCK), .DAC_SDI(DAC_SDI),
    .clear_status(clear_status),
    .frame_valid(frame_valid), .frame_err(frame_err),
    .frame_cmd(frame_cmd), .frame_addr(frame_addr), .frame_data(frame_data),
    .DAC_ROFS(DAC_ROFS), .DAC_OOFS(DAC_OOFS), .DAC_BIAS(DAC_BIAS),
    .DAC_CALP(DAC_CALP), .DAC_CALN(DAC_CALN),
    .ctrl_cnt(ctrl_cnt), .all_set(all_set)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_bad  = 0;
  int n_puls = 0;

  typedef struct {
    bit               err;
    logic [3:0]       cmd;
    logic [3:0]       addr;
    logic [15:0]      data;
    logic [4:0][15:0] sh;   // 0 ROFS, 1 OOFS, 2 BIAS, 3 CALP, 4 CALN
    logic [7:0]       ctrl;
    bit               all;
    int               rise_cyc;
  } exp_t;

  exp_t exp_q[$];

  // Reference state: what the receiver should hold after each frame.
  logic [3:0]       m_cmd, m_addr;
  logic [15:0]      m_data;
  logic [4:0][15:0] m_sh;
  logic [4:0]       m_written;
  logic [7:0]       m_ctrl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Channel index for a shadow address, -1 when the address has no shadow.
  function automatic int chan_of(input logic [3:0] a);
    case (a)
      4'd3: return 0;
      4'd7: return 1;
      4'd6: return 2;
      4'd2: return 3;
      4'd1: return 4;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_cmd = '0; m_addr = '0; m_data = '0; m_sh = '0; m_written = '0; m_ctrl = '0;
  endtask

  task automatic model_clear();
    m_written = '0;
    m_ctrl    = '0;
  endtask

  // Apply one CS-framed burst of nbits to the model and queue the result.
  task automatic model_frame(input int nbits, input logic [31:0] bits, input bit clr, input int rc);
    exp_t e;
    int   ch;
    if (clr) model_clear();
    e.err = (nbits != FRAME_BITS);
    if (!e.err) begin
      m_cmd  = bits[23:20];
      m_addr = bits[19:16];
      m_data = bits[15:0];
      if (m_cmd == 4'b0011) begin
        ch = chan_of(m_addr);
        if (ch >= 0) begin
          m_sh[ch]      = m_data;
          m_written[ch] = 1'b1;
        end
      end
      if (m_cmd == 4'b0100) m_ctrl = m_ctrl + 8'd1;
    end
    e.cmd = m_cmd; e.addr = m_addr; e.data = m_data; e.sh = m_sh;
    e.ctrl = m_ctrl; e.all = (m_written == 5'b11111); e.rise_cyc = rc;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one frame: bits are sent MSB first from bits[nbits-1]. collide adds
  // an SCK rise in the same cycle as the CS rise; clr pulses clear_status in
  // the cycle the receiver evaluates the frame.
  task automatic send_frame(input int nbits, input logic [31:0] bits, input int hp,
                            input bit collide, input bit clr);
    DAC_CS = 1'b0;
    tick(2);
    for (int i = 0; i < nbits; i++) begin
      DAC_SDI = bits[nbits-1-i];
      DAC_SCK = 1'b0;
      tick(hp);
      DAC_SCK = 1'b1;
      tick(hp);
    end
    DAC_SCK = 1'b0;
    tick(hp);
    if (collide) begin
      DAC_SDI = 1'($urandom);
      DAC_SCK = 1'b1;
    end
    DAC_CS = 1'b1;
    model_frame(nbits, bits, clr, cyc);
    if (clr) begin
      tick(3);
      clear_status = 1'b1;
      tick(1);
      clear_status = 1'b0;
      tick(5);
    end else begin
      tick(9);
    end
    DAC_SCK = 1'b0;
    tick(1);
  endtask

  task automatic pulse_clear();
    clear_status = 1'b1;
    tick(1);
    clear_status = 1'b0;
    model_clear();
    check("clear_ctrl_cnt", 32'(ctrl_cnt), 32'(0));
    check("clear_all_set", 32'(all_set), 32'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(frame_valid), 32'(0));
    check({tag, "_err"}, 32'(frame_err), 32'(0));
    check({tag, "_fields"}, {8'd0, frame_cmd, frame_addr, frame_data}, 32'(0));
    check({tag, "_rofs_oofs"}, {DAC_ROFS, DAC_OOFS}, 32'(0));
    check({tag, "_bias_calp"}, {DAC_BIAS, DAC_CALP}, 32'(0));
    check({tag, "_caln"}, 32'(DAC_CALN), 32'(0));
    check({tag, "_ctrl_all"}, {23'd0, ctrl_cnt, all_set}, 32'(0));
  endtask

  // Monitor: every result pulse must match the oldest queued prediction.
  always @(negedge clk) begin
    if (rst === 1'b1 && (frame_valid === 1'b1 || frame_err === 1'b1)) begin
      exp_t e;
      logic [4:0][15:0] act_sh;
      n_puls++;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, frame_valid, frame_err}, 32'(0));
      end else begin
        e = exp_q.pop_front();
        act_sh[0] = DAC_ROFS; act_sh[1] = DAC_OOFS; act_sh[2] = DAC_BIAS;
        act_sh[3] = DAC_CALP; act_sh[4] = DAC_CALN;
        check("frame_valid", 32'(frame_valid), 32'(!e.err));
        check("frame_err", 32'(frame_err), 32'(e.err));
        check("latency", 32'(cyc - e.rise_cyc), 32'(SYNC_STAGES + 2));
        check("frame_cmd", 32'(frame_cmd), 32'(e.cmd));
        check("frame_addr", 32'(frame_addr), 32'(e.addr));
        check("frame_data", 32'(frame_data), 32'(e.data));
        for (int c = 0; c < 5; c++) check($sformatf("shadow%0d", c), 32'(act_sh[c]), 32'(e.sh[c]));
        check("ctrl_cnt", 32'(ctrl_cnt), 32'(e.ctrl));
        check("all_set", 32'(all_set), 32'(e.all));
      end
    end
  end

  initial begin
    int          pulses_before;
    int          nbits, hp;
    logic [3:0]  cmd, addr;
    logic [15:0] data;
    logic [3:0]  addr_tab [5];
    addr_tab[0] = 4'd3; addr_tab[1] = 4'd7; addr_tab[2] = 4'd6;
    addr_tab[3] = 4'd2; addr_tab[4] = 4'd1;

    // Reset with CS low and SCK toggling.
    rst = 1'b0; DAC_CS = 1'b0; DAC_SCK = 1'b0; DAC_SDI = 1'b0; clear_status = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      DAC_SCK = ~DAC_SCK;
      DAC_SDI = 1'($urandom);
      tick(1);
    end
    check_all_zero("reset");

    // Release with CS still low: nothing may pulse while CS stays low.
    pulses_before = n_puls;
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      DAC_SCK = ~DAC_SCK;
      tick(1);
    end
    check("no_pulse_cs_low", 32'(n_puls), 32'(pulses_before));
    rst = 1'b0; DAC_CS = 1'b1; DAC_SCK = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(4);

    // Single write to ROFS.
    send_frame(24, 32'h0033_1234, 1, 1'b0, 1'b0);
    check("single_rofs", 32'(DAC_ROFS), 32'h1234);

    // Full controller sequence at the fastest SCK rate.
    pulse_clear();
    send_frame(24, 32'h0033_0100, 1, 1'b0, 1'b0);
    send_frame(24, 32'h0037_0200, 1, 1'b0, 1'b0);
    send_frame(24, 32'h0036_0300, 1, 1'b0, 1'b0);
    send_frame(24, 32'h0032_0400, 1, 1'b0, 1'b0);
    send_frame(24, 32'h0031_0500, 1, 1'b0, 1'b0);
    send_frame(24, 32'h0040_0000, 1, 1'b0, 1'b0);
    send_frame(24, 32'h0044_0000, 1, 1'b0, 1'b0);
    send_frame(24, 32'h0045_0000, 1, 1'b0, 1'b0);
    check("seq_ctrl_cnt", 32'(ctrl_cnt), 32'd3);
    check("seq_all_set", 32'(all_set), 32'd1);
    check("seq_addr", 32'(frame_addr), 32'd5);

    // Length errors, then a good frame.
    send_frame(23, 32'h0019_1111, 2, 1'b0, 1'b0);
    send_frame(25, 32'h0166_2222, 2, 1'b0, 1'b0);
    send_frame(0, 32'h0, 1, 1'b0, 1'b0);
    send_frame(24, 32'h0036_5A5A, 2, 1'b0, 1'b0);

    // SCK rise coincident with CS rise after 24 edges.
    send_frame(24, 32'h0032_C3C3, 1, 1'b1, 1'b0);
    // clear_status in the evaluation cycle of a CALN write.
    send_frame(24, 32'h0031_7E7E, 1, 1'b0, 1'b1);
    check("clr_collide_mask", 32'(dut.mask), 32'b10000);
    check("clr_collide_all_set", 32'(all_set), 32'd0);

    // Reset mid-frame after 12 bits, then a fresh frame.
    pulses_before = n_puls;
    DAC_CS = 1'b0;
    tick(2);
    for (int i = 0; i < 12; i++) begin
      DAC_SDI = 1'($urandom);
      DAC_SCK = 1'b0; tick(1);
      DAC_SCK = 1'b1; tick(1);
    end
    rst = 1'b0;
    model_reset();
    DAC_CS = 1'b1; DAC_SCK = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(4);
    check("midframe_no_pulse", 32'(n_puls), 32'(pulses_before));
    send_frame(24, 32'h0037_ABCD, 1, 1'b0, 1'b0);
    check("midframe_oofs", 32'(DAC_OOFS), 32'hABCD);

    // Randomized traffic.
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 9))
        0: nbits = 23;
        1: nbits = 25;
        2: nbits = 0;
        default: nbits = 24;
      endcase
      case ($urandom_range(0, 3))
        0, 1: cmd = 4'b0011;
        2:    cmd = 4'b0100;
        default: cmd = 4'($urandom);
      endcase
      addr = ($urandom_range(0, 3) != 0) ? addr_tab[$urandom_range(0, 4)] : 4'($urandom);
      data = 16'($urandom);
      hp   = $urandom_range(1, 3);
      send_frame(nbits, {7'($urandom), 1'b1, cmd, addr, data}, hp,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0);
      if ($urandom_range(0, 9) == 0) pulse_clear();
    end

    // Drain the scoreboard.
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
    check("scoreboard_drain", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
